// File: rtl/instruction_fetch.sv
// Fetch stage: issues instruction-memory reads at the current PC, feeds next_address back to the PC
// and loads the IF/ID register, handling wait states, decode stalls and redirects.
module instruction_fetch #(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0080,
  parameter int unsigned PC_STEP    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic [31:0] next_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall_in,
  input  logic        interrupt,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic [2:0]  state, next_state;
  logic [31:0] req_addr;
  logic [31:0] buf_instr, buf_pc_plus4;

  logic        redirect, accept;
  logic [31:0] target;
  logic [31:0] pc_plus4, req_plus4;
  logic        load_ifid, load_buf, load_req;
  logic [31:0] load_instr, load_pc_plus4;

  assign redirect  = interrupt | jump | branch_taken;
  assign target    = interrupt ? INT_VECTOR : (jump ? jump_target : branch_target);
  assign accept    = !ifid_valid || !stall_in;
  assign pc_plus4  = pc_in + STEP;
  assign req_plus4 = req_addr + STEP;

  // Next state, memory request, next PC and IF/ID load selection
  always_comb begin
    next_state    = state;
    imem_req      = 1'b0;
    imem_addr     = req_addr;
    next_address  = pc_in;
    load_ifid     = 1'b0;
    load_buf      = 1'b0;
    load_req      = 1'b0;
    load_instr    = imem_rdata;
    load_pc_plus4 = req_plus4;

    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        imem_req  = accept;
        imem_addr = pc_in;
        load_req  = accept;
        if (accept) begin
          if (imem_ack) begin
            if (!redirect) begin
              load_ifid     = 1'b1;
              load_pc_plus4 = pc_plus4;
              next_address  = pc_plus4;
            end
          end else begin
            next_state = redirect ? DRAIN : WAIT;
          end
        end
      end
      WAIT: begin
        imem_req = 1'b1;
        if (redirect) begin
          next_state = imem_ack ? FETCH : DRAIN;
        end else if (imem_ack) begin
          next_address = req_plus4;
          if (accept) begin
            load_ifid  = 1'b1;
            next_state = FETCH;
          end else begin
            load_buf   = 1'b1;
            next_state = HOLD;
          end
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (imem_ack && !redirect) next_state = FETCH;
      end
      HOLD: begin
        if (redirect) begin
          next_state = FETCH;
        end else if (!stall_in) begin
          load_ifid     = 1'b1;
          load_instr    = buf_instr;
          load_pc_plus4 = buf_pc_plus4;
          next_state    = FETCH;
        end
      end
      default: next_state = IDLE;
    endcase

    if (redirect) next_address = target;

    // The PC must hold and memory must see no request while in reset
    if (reset) begin
      imem_req     = 1'b0;
      next_address = pc_in;
      load_ifid    = 1'b0;
      load_buf     = 1'b0;
      load_req     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      req_addr      <= 32'h0;
      buf_instr     <= 32'h0;
      buf_pc_plus4  <= 32'h0;
      ifid_instr    <= 32'h0;
      ifid_pc_plus4 <= 32'h0;
      ifid_valid    <= 1'b0;
    end else begin
      state <= next_state;
      if (load_req) req_addr <= pc_in;
      if (redirect) begin
        ifid_valid   <= 1'b0;
        buf_instr    <= 32'h0;
        buf_pc_plus4 <= 32'h0;
      end else begin
        if (load_ifid) begin
          ifid_instr    <= load_instr;
          ifid_pc_plus4 <= load_pc_plus4;
          ifid_valid    <= 1'b1;
        end
        if (load_buf) begin
          buf_instr    <= imem_rdata;
          buf_pc_plus4 <= req_plus4;
        end
      end
    end
  end

endmodule
